// File: rtl/bitwise_nand_checker.sv
// bitwise_nand_checker: checks NAND datapath beats, counts mismatches, captures first failure, MISR signature
module bitwise_nand_checker #(
  parameter int WIDTH = 32,
  parameter int NUM_VECTORS = 10,
  parameter logic [31:0] POLY = 32'h04C11DB7,
  localparam int CW = $clog2(NUM_VECTORS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] out_dut,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CW-1:0]    err_count,
  output logic [CW-1:0]    first_err_idx,
  output logic [WIDTH-1:0] first_err_exp,
  output logic [WIDTH-1:0] first_err_got,
  output logic [WIDTH-1:0] signature
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [WIDTH-1:0] P = WIDTH'(POLY);
  state_t r_state, w_next;
  logic [CW-1:0] r_vec_cnt;
  logic [WIDTH-1:0] w_exp;
  logic w_acc, w_last, w_start, w_mis;
  assign in_ready = r_state == RUN;
  assign busy = r_state == RUN;
  assign done = r_state == DONE;
  assign pass = done && err_count == '0;
  assign w_acc = in_valid && in_ready;
  assign w_last = w_acc && r_vec_cnt == CW'(NUM_VECTORS - 1);
  assign w_start = start && r_state != RUN;
  assign w_exp = ~(in1 & in2);
  assign w_mis = out_dut != w_exp;
  always_comb w_next = r_state == RUN ? (w_last ? DONE : RUN) : (start ? RUN : r_state);
  always_ff @(posedge clk)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  always_ff @(posedge clk)
    if (rst || w_start) begin
      r_vec_cnt <= '0;
      err_count <= '0;
      first_err_idx <= '0;
      first_err_exp <= '0;
      first_err_got <= '0;
      signature <= '0;
    end else if (w_acc) begin
      if (w_mis && err_count == '0) begin
        first_err_idx <= r_vec_cnt;
        first_err_exp <= w_exp;
        first_err_got <= out_dut;
      end
      err_count <= err_count + CW'(w_mis);
      signature <= ({signature[WIDTH-2:0], 1'b0} ^ (signature[WIDTH-1] ? P : '0)) ^ out_dut;
      r_vec_cnt <= r_vec_cnt + 1'b1;
    end
endmodule

// File: tb/tb_bitwise_nand_checker.sv
// tb_bitwise_nand_checker: randomized scoreboard bench for bitwise_nand_checker (10-beat and 2-beat instances)
module tb_bitwise_nand_checker;
  localparam logic [31:0] POLY = 32'h04C11DB7;
  logic clk = 0, rst = 1;
  logic start = 0, vld = 0, rdy, busy, done, pass;
  logic [31:0] a = 0, b = 0, o = 0, fexp, fgot, sig;
  logic [3:0] err, idx;
  logic s_start = 0, s_vld = 0, s_rdy, s_busy, s_done, s_pass;
  logic [31:0] s_a = 0, s_b = 0, s_o = 0, s_fexp, s_fgot, s_sig;
  logic [1:0] s_err, s_idx;
  typedef struct {int err; int idx; logic [31:0] fexp; logic [31:0] fgot; logic [31:0] sig; bit pass;} exp_t;
  exp_t q0[$], q1[$];
  exp_t e0, e1;
  logic [31:0] va[$], vb[$], vo[$];
  int errors = 0, checks = 0;
  int m0_acc = 0, m1_acc = 0;
  bit m0_pd = 0, m0_pa = 0, m1_pd = 0, m1_pa = 0;

  bitwise_nand_checker #(.WIDTH(32), .NUM_VECTORS(10), .POLY(POLY)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(vld), .in_ready(rdy),
    .in1(a), .in2(b), .out_dut(o), .busy(busy), .done(done), .pass(pass),
    .err_count(err), .first_err_idx(idx), .first_err_exp(fexp), .first_err_got(fgot), .signature(sig));
  bitwise_nand_checker #(.WIDTH(32), .NUM_VECTORS(2), .POLY(POLY)) dut2 (
    .clk(clk), .rst(rst), .start(s_start), .in_valid(s_vld), .in_ready(s_rdy),
    .in1(s_a), .in2(s_b), .out_dut(s_o), .busy(s_busy), .done(s_done), .pass(s_pass),
    .err_count(s_err), .first_err_idx(s_idx), .first_err_exp(s_fexp), .first_err_got(s_fgot), .signature(s_sig));

  always #5 clk = ~clk;

  task automatic chk(string n, logic [63:0] g, logic [63:0] e);
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", n, g, e);
    end
  endtask

  task automatic flag(string n);
    checks++;
    errors++;
    $display("FAIL %s got=timeout/unexpected expected=event", n);
  endtask

  // Reference: walks the beat list applying the NAND rule, first-error capture and MISR step
  function automatic exp_t model();
    exp_t e;
    e = '{default: 0};
    foreach (va[i]) begin
      logic [31:0] x;
      x = ~(va[i] & vb[i]);
      if (vo[i] != x) begin
        if (e.err == 0) begin
          e.idx = i;
          e.fexp = x;
          e.fgot = vo[i];
        end
        e.err++;
      end
      e.sig = (e.sig << 1) ^ (e.sig[31] ? POLY : 32'h0) ^ vo[i];
    end
    e.pass = e.err == 0;
    return e;
  endfunction

  task automatic gen(int n, int f1, int f2);
    va = {}; vb = {}; vo = {};
    for (int i = 0; i < n; i++) begin
      logic [31:0] x, y, z;
      x = $urandom; y = $urandom; z = ~(x & y);
      if (i == f1 || i == f2) z = z ^ (32'h1 << $urandom_range(31));
      va.push_back(x); vb.push_back(y); vo.push_back(z);
    end
  endtask

  task automatic set_in(bit sel, logic st, logic v, logic [31:0] x, logic [31:0] y, logic [31:0] z);
    if (sel) begin s_start = st; s_vld = v; s_a = x; s_b = y; s_o = z; end
    else begin start = st; vld = v; a = x; b = y; o = z; end
  endtask

  task automatic drive(bit sel, bit bubble, bit mid_start, bit sv_start);
    int t;
    if (sel) q1.push_back(model()); else q0.push_back(model());
    set_in(sel, 1, sv_start, $urandom, $urandom, $urandom);
    @(posedge clk) #1;
    set_in(sel, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("start_clr_sig", sel ? s_sig : sig, 0);
    chk("start_clr_err", sel ? s_err : err, 0);
    chk("start_clr_done", sel ? s_done : done, 0);
    chk("start_busy", sel ? s_busy : busy, 1);
    @(posedge clk) #1;
    foreach (va[i]) begin
      if (bubble) begin
        set_in(sel, mid_start && i == 4, 0, 0, 0, 0);
        @(posedge clk) #1;
      end
      set_in(sel, 0, 1, va[i], vb[i], vo[i]);
      t = 0;
      while (!(sel ? s_rdy : rdy) && t < 20) begin @(posedge clk) #1; t++; end
      if (t >= 20) flag("ready_wait");
      @(posedge clk) #1;
    end
    set_in(sel, 0, 0, 0, 0, 0);
    t = 0;
    while (!(sel ? s_done : done) && t < 10) begin @(posedge clk) #1; t++; end
    if (t >= 10) flag("done_wait");
    repeat (2) @(posedge clk) #1;
  endtask

  always @(negedge clk) begin
    if (rst) begin m0_acc = 0; m0_pd = 0; m0_pa = 0; end
    else begin
      if (done && !m0_pd) begin
        if (q0.size() == 0) flag("m0_unexpected_done");
        else begin
          e0 = q0.pop_front();
          chk("m0_err", err, e0.err);
          chk("m0_idx", idx, e0.idx);
          chk("m0_fexp", fexp, e0.fexp);
          chk("m0_fgot", fgot, e0.fgot);
          chk("m0_sig", sig, e0.sig);
          chk("m0_pass", pass, e0.pass);
          chk("m0_accepts", m0_acc, 10);
          chk("m0_done_latency", m0_pa, 1);
        end
        m0_acc = 0;
      end
      m0_pa = vld && rdy;
      if (m0_pa) m0_acc++;
      m0_pd = done;
    end
  end

  always @(negedge clk) begin
    if (rst) begin m1_acc = 0; m1_pd = 0; m1_pa = 0; end
    else begin
      if (s_done && !m1_pd) begin
        if (q1.size() == 0) flag("m1_unexpected_done");
        else begin
          e1 = q1.pop_front();
          chk("m1_err", s_err, e1.err);
          chk("m1_idx", s_idx, e1.idx);
          chk("m1_fexp", s_fexp, e1.fexp);
          chk("m1_fgot", s_fgot, e1.fgot);
          chk("m1_sig", s_sig, e1.sig);
          chk("m1_pass", s_pass, e1.pass);
          chk("m1_accepts", m1_acc, 2);
          chk("m1_done_latency", m1_pa, 1);
        end
        m1_acc = 0;
      end
      m1_pa = s_vld && s_rdy;
      if (m1_pa) m1_acc++;
      m1_pd = s_done;
    end
  end

  task automatic chk_zero(string n);
    chk({n, "_ready"}, rdy, 0);
    chk({n, "_busy"}, busy, 0);
    chk({n, "_done"}, done, 0);
    chk({n, "_pass"}, pass, 0);
    chk({n, "_err"}, err, 0);
    chk({n, "_idx"}, idx, 0);
    chk({n, "_fexp"}, fexp, 0);
    chk({n, "_fgot"}, fgot, 0);
    chk({n, "_sig"}, sig, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(posedge clk) #1;
    rst = 0;
    @(negedge clk);
    chk_zero("reset");
    // reset mid-run: three mismatching all-zero-operand beats, then rst for two cycles
    @(posedge clk) #1;
    start = 1;
    @(posedge clk) #1;
    start = 0;
    vld = 1; a = 0; b = 0; o = 0;
    repeat (3) @(posedge clk) #1;
    vld = 0;
    @(negedge clk);
    chk("t1_err_pre", err, 3);
    chk("t1_fexp_pre", fexp, 32'hFFFFFFFF);
    @(posedge clk) #1;
    rst = 1; start = 1; vld = 1;
    @(posedge clk) #1;
    chk_zero("t1_rst_edge");
    @(posedge clk) #1;
    rst = 0; start = 0; vld = 0;
    @(negedge clk);
    chk_zero("t1_after");
    @(posedge clk) #1;
    // all pass, first beat 5 NAND 3
    gen(10, -1, -1);
    va[0] = 5; vb[0] = 3; vo[0] = 32'hFFFFFFFE;
    drive(0, 0, 0, 0);
    chk("t2_pass", pass, 1);
    chk("t2_err", err, 0);
    // single fault at beat 3
    gen(10, -1, -1);
    va[3] = 32'h1F; vb[3] = 32'h1F; vo[3] = 32'hFFFFFFFF;
    drive(0, 0, 0, 0);
    chk("t3_err", err, 1);
    chk("t3_idx", idx, 3);
    chk("t3_fexp", fexp, 32'hFFFFFFE0);
    chk("t3_fgot", fgot, 32'hFFFFFFFF);
    chk("t3_pass", pass, 0);
    // faults at beats 2 and 7
    gen(10, 2, 7);
    drive(0, 0, 0, 0);
    chk("t4_err", err, 2);
    chk("t4_idx", idx, 2);
    // start with a simultaneous valid in DONE: the beat must be dropped
    gen(10, -1, 5);
    drive(0, 0, 0, 1);
    // bubbles and ignored start in RUN
    gen(10, 1, -1);
    drive(0, 1, 1, 0);
    // random runs with random fault positions
    for (int r = 0; r < 3; r++) begin
      gen(10, $urandom_range(12), $urandom_range(12));
      drive(0, r[0], 0, 0);
    end
    // signature on the 2-beat instance
    gen(2, -1, -1);
    vo[0] = 1; vo[1] = 2;
    drive(1, 0, 0, 0);
    chk("t6_sig", s_sig, 0);
    gen(2, -1, -1);
    vo[0] = 3; vo[1] = 5;
    drive(1, 0, 0, 0);
    chk("t6_sig2", s_sig, 3);
    gen(2, 0, -1);
    drive(1, 1, 0, 0);
    repeat (3) @(posedge clk) #1;
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
